// File: rtl/mmio_slot_fabric.sv
// MMIO slot interconnect: decodes FPro bus accesses into per-slot strobes, muxes read data,
// and hosts fabric control registers (error capture, irq aggregation, access counter).
module mmio_slot_fabric #(
  parameter int                N_SLOT    = 64,
  parameter int                REG_AW    = 5,
  parameter logic [N_SLOT-1:0] SLOT_MAP  = '1,
  parameter int                CTRL_SLOT = N_SLOT - 1,
  parameter int                N_IRQ     = 16,
  parameter int                RD_PIPE   = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          mmio_cs,
  input  logic                          mmio_wr,
  input  logic                          mmio_rd,
  input  logic [20:0]                   mmio_addr,
  input  logic [31:0]                   mmio_wr_data,
  output logic [31:0]                   mmio_rd_data,
  output logic [N_SLOT-1:0]             slot_cs_array,
  output logic [N_SLOT-1:0]             slot_mem_rd_array,
  output logic [N_SLOT-1:0]             slot_mem_wr_array,
  output logic [N_SLOT-1:0][REG_AW-1:0] slot_reg_addr_array,
  output logic [N_SLOT-1:0][31:0]       slot_wr_data_array,
  input  logic [N_SLOT-1:0][31:0]       slot_rd_data_array,
  input  logic [N_IRQ-1:0]              slot_irq,
  output logic                          irq
);

  localparam int SW = $clog2(N_SLOT);
  localparam int MW = (N_SLOT < 32) ? N_SLOT : 32;

  logic [SW-1:0]     slot;
  logic [REG_AW-1:0] reg_addr;
  logic [2:0]        sel;
  logic [N_SLOT-1:0] map_eff;
  logic              is_ctrl, mapped, err_rw, err_unmap, valid, acc_ok, ctrl_wr;
  logic [1:0]        err_flags;
  logic [20:0]       err_addr;
  logic [N_IRQ-1:0]  irq_en, irq_pend, irq_d;
  logic [31:0]       acc_cnt;
  logic [31:0]       ctrl_rd, rd_val;

  assign slot     = mmio_addr[SW+REG_AW-1:REG_AW];
  assign reg_addr = mmio_addr[REG_AW-1:0];
  assign sel      = reg_addr[2:0];

  always_comb begin
    map_eff            = SLOT_MAP;
    map_eff[CTRL_SLOT] = 1'b1;
  end

  assign is_ctrl   = (slot == SW'(CTRL_SLOT));
  assign mapped    = map_eff[slot];
  assign err_rw    = mmio_cs & mmio_rd & mmio_wr;
  assign err_unmap = mmio_cs & (mmio_rd | mmio_wr) & ~mapped;
  assign valid     = mmio_cs & (mmio_rd ^ mmio_wr);
  assign acc_ok    = valid & mapped;
  assign ctrl_wr   = acc_ok & is_ctrl & mmio_wr;

  // Strobes are held low while reset is asserted so slots never see a stray access.
  always_comb begin
    slot_cs_array     = '0;
    slot_mem_rd_array = '0;
    slot_mem_wr_array = '0;
    if (acc_ok && !is_ctrl && !reset) begin
      slot_cs_array[slot]     = 1'b1;
      slot_mem_rd_array[slot] = mmio_rd;
      slot_mem_wr_array[slot] = mmio_wr;
    end
  end

  assign slot_reg_addr_array = {N_SLOT{reg_addr}};
  assign slot_wr_data_array  = {N_SLOT{mmio_wr_data}};

  always_comb begin
    ctrl_rd = '0;
    case (sel)
      3'd0:    ctrl_rd = {29'd0, irq, err_flags};
      3'd1:    ctrl_rd = 32'(err_addr);
      3'd2:    ctrl_rd = 32'(irq_en);
      3'd3:    ctrl_rd = 32'(irq_pend);
      3'd4:    ctrl_rd = acc_cnt;
      3'd5:    ctrl_rd = 32'(map_eff[MW-1:0]);
      default: ctrl_rd = '0;
    endcase
  end

  always_comb begin
    rd_val = '0;
    if (!err_rw && mapped)
      rd_val = is_ctrl ? ctrl_rd : slot_rd_data_array[slot];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_flags <= '0;
      err_addr  <= '0;
      irq_en    <= '0;
      irq_pend  <= '0;
      irq_d     <= '0;
      irq       <= 1'b0;
      acc_cnt   <= '0;
    end else begin
      irq_d <= slot_irq;
      // A new rising edge wins over a W1C in the same cycle.
      irq_pend <= (irq_pend & ~((ctrl_wr && sel == 3'd3) ? mmio_wr_data[N_IRQ-1:0] : '0))
                  | (slot_irq & ~irq_d);
      irq <= |(irq_pend & irq_en);
      if (ctrl_wr && sel == 3'd2)
        irq_en <= mmio_wr_data[N_IRQ-1:0];
      err_flags <= (err_flags & ~((ctrl_wr && sel == 3'd0) ? mmio_wr_data[1:0] : 2'b00))
                   | {err_rw, err_unmap};
      if ((err_rw || err_unmap) && err_flags == 2'b00)
        err_addr <= mmio_addr;
      if (ctrl_wr && sel == 3'd4)
        acc_cnt <= '0;
      else if (acc_ok)
        acc_cnt <= acc_cnt + 32'd1;
    end
  end

  generate
    if (RD_PIPE != 0) begin : g_rd_pipe
      logic [31:0] rd_q;
      always_ff @(posedge clk or posedge reset) begin
        if (reset)
          rd_q <= '0;
        else if (valid && mmio_rd)
          rd_q <= rd_val;
      end
      assign mmio_rd_data = rd_q;
    end else begin : g_rd_comb
      assign mmio_rd_data = rd_val;
    end
  endgenerate

endmodule

// File: tb/tb_mmio_slot_fabric.sv
// Self-checking bench for mmio_slot_fabric: one combinational-read and one registered-read
// instance driven in parallel with a 16-slot map that leaves slots 7 and 9 unmapped.
module tb_mmio_slot_fabric;

  localparam int          NS     = 16;
  localparam logic [15:0] TB_MAP = 16'hFD7F;

  logic clk = 1'b0;
  logic reset;
  logic mmio_cs, mmio_wr, mmio_rd;
  logic [20:0] mmio_addr;
  logic [31:0] mmio_wr_data;
  logic [NS-1:0][31:0] srd;
  logic [15:0] slot_irq;

  logic [31:0] rd0, rd1;
  logic [NS-1:0] cs0, mr0, mw0, cs1, mr1, mw1;
  logic [NS-1:0][4:0] ra0, ra1;
  logic [NS-1:0][31:0] wd0, wd1;
  logic irq0, irq1;

  int n_chk = 0;
  int n_fail = 0;
  int acc_exp = 0;
  logic [31:0] pipe_exp = '0;

  always #5 clk = ~clk;

  mmio_slot_fabric #(.N_SLOT(NS), .REG_AW(5), .SLOT_MAP(TB_MAP), .CTRL_SLOT(15),
                     .N_IRQ(16), .RD_PIPE(0)) d0 (
    .clk(clk), .reset(reset), .mmio_cs(mmio_cs), .mmio_wr(mmio_wr), .mmio_rd(mmio_rd),
    .mmio_addr(mmio_addr), .mmio_wr_data(mmio_wr_data), .mmio_rd_data(rd0),
    .slot_cs_array(cs0), .slot_mem_rd_array(mr0), .slot_mem_wr_array(mw0),
    .slot_reg_addr_array(ra0), .slot_wr_data_array(wd0), .slot_rd_data_array(srd),
    .slot_irq(slot_irq), .irq(irq0));

  mmio_slot_fabric #(.N_SLOT(NS), .REG_AW(5), .SLOT_MAP(TB_MAP), .CTRL_SLOT(15),
                     .N_IRQ(16), .RD_PIPE(1)) d1 (
    .clk(clk), .reset(reset), .mmio_cs(mmio_cs), .mmio_wr(mmio_wr), .mmio_rd(mmio_rd),
    .mmio_addr(mmio_addr), .mmio_wr_data(mmio_wr_data), .mmio_rd_data(rd1),
    .slot_cs_array(cs1), .slot_mem_rd_array(mr1), .slot_mem_wr_array(mw1),
    .slot_reg_addr_array(ra1), .slot_wr_data_array(wd1), .slot_rd_data_array(srd),
    .slot_irq(slot_irq), .irq(irq1));

  typedef struct {
    logic        cs, rd, wr;
    logic [20:0] addr;
    logic [31:0] wdata;
    logic [15:0] e_cs, e_rd, e_wr;
    logic [31:0] e_data;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic cs, input logic rd, input logic wr,
                       input logic [20:0] addr, input logic [31:0] wd);
    @(negedge clk);
    mmio_cs = cs; mmio_rd = rd; mmio_wr = wr; mmio_addr = addr; mmio_wr_data = wd;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    mmio_cs = 1'b0; mmio_rd = 1'b0; mmio_wr = 1'b0;
  endtask

  task automatic rd_chk(input string nm, input logic [20:0] addr, input logic [31:0] exp);
    drive(1'b1, 1'b1, 1'b0, addr, 32'd0);
    chk(nm, rd0, exp);
    tick();
    chk({nm, "_pipe"}, rd1, exp);
    acc_exp++;
  endtask

  task automatic wr_ctl(input logic [20:0] addr, input logic [31:0] wd);
    drive(1'b1, 1'b0, 1'b1, addr, wd);
    tick();
    acc_exp++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 1'b1, 21'h041,    32'h0000_00A5, 16'h0004, 16'h0000, 16'h0004, 32'hA000_0002};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 21'h060,    32'h0,         16'h0008, 16'h0008, 16'h0000, 32'h0000_1234};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 21'h01F,    32'h0,         16'h0001, 16'h0001, 16'h0000, 32'hA000_0000};
    vecs[3]  = '{1'b1, 1'b0, 1'b1, 21'h1C2,    32'h0000_005A, 16'h4000, 16'h0000, 16'h4000, 32'hA000_000E};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 21'h060,    32'h0,         16'h0000, 16'h0000, 16'h0000, 32'h0000_1234};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 21'h041,    32'h0,         16'h0000, 16'h0000, 16'h0000, 32'hA000_0002};
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 21'h103,    32'h0,         16'h0100, 16'h0100, 16'h0000, 32'hA000_0008};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 21'h1E5,    32'h0,         16'h0000, 16'h0000, 16'h0000, 32'h0000_FD7F};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 21'h1E6,    32'h0,         16'h0000, 16'h0000, 16'h0000, 32'h0};
    vecs[9]  = '{1'b1, 1'b0, 1'b1, 21'h1E7,    32'h0000_FFFF, 16'h0000, 16'h0000, 16'h0000, 32'h0};
    vecs[10] = '{1'b1, 1'b1, 1'b0, 21'h100041, 32'h0,         16'h0004, 16'h0004, 16'h0000, 32'hA000_0002};

    for (int i = 0; i < NS; i++) srd[i] = 32'hA000_0000 | 32'(i);
    srd[3] = 32'h0000_1234;
    slot_irq = '0;
    mmio_cs = 1'b0; mmio_rd = 1'b0; mmio_wr = 1'b0; mmio_addr = '0; mmio_wr_data = '0;
    reset = 1'b1;
    #3;
    chk("rst_pipe_data", rd1, 32'h0);
    chk("rst_irq", 32'(irq0 | irq1), 32'h0);
    chk("rst_strobes", 32'(cs0 | mr0 | mw0), 32'h0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].cs, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata);
      chk($sformatf("vec%0d_cs", i), 32'(cs0), 32'(vecs[i].e_cs));
      chk($sformatf("vec%0d_rd", i), 32'(mr0), 32'(vecs[i].e_rd));
      chk($sformatf("vec%0d_wr", i), 32'(mw0), 32'(vecs[i].e_wr));
      chk($sformatf("vec%0d_data", i), rd0, vecs[i].e_data);
      chk($sformatf("vec%0d_regaddr", i), 32'(ra0[i % NS]), 32'(vecs[i].addr[4:0]));
      chk($sformatf("vec%0d_wdata", i), wd0[(i + 5) % NS], vecs[i].wdata);
      if (vecs[i].cs && (vecs[i].rd ^ vecs[i].wr)) acc_exp++;
      if (vecs[i].cs && vecs[i].rd && !vecs[i].wr) pipe_exp = vecs[i].e_data;
      tick();
      chk($sformatf("vec%0d_pipe", i), rd1, pipe_exp);
    end

    rd_chk("acc_after_table", 21'h1E4, 32'(acc_exp));
    rd_chk("status_clean", 21'h1E0, 32'h0);
    rd_chk("irq_en_rst", 21'h1E2, 32'h0);
    rd_chk("pend_rst", 21'h1E3, 32'h0);

    drive(1'b1, 1'b1, 1'b0, 21'h0E4, 32'h0);
    chk("unmap_strobes", 32'(cs0 | mr0 | mw0), 32'h0);
    chk("unmap_data", rd0, 32'h0);
    tick();
    chk("unmap_pipe", rd1, 32'h0);
    rd_chk("status_unmap", 21'h1E0, 32'h1);
    rd_chk("err_addr_first", 21'h1E1, 32'h0E4);
    drive(1'b1, 1'b0, 1'b1, 21'h120, 32'h77);
    chk("unmap2_strobes", 32'(cs0 | mw0), 32'h0);
    tick();
    rd_chk("err_addr_kept", 21'h1E1, 32'h0E4);
    rd_chk("status_still", 21'h1E0, 32'h1);
    wr_ctl(21'h1E0, 32'h3);
    rd_chk("status_cleared", 21'h1E0, 32'h0);

    drive(1'b1, 1'b1, 1'b1, 21'h041, 32'h5);
    chk("rw_strobes", 32'(cs0 | mr0 | mw0), 32'h0);
    chk("rw_data", rd0, 32'h0);
    tick();
    rd_chk("status_rw", 21'h1E0, 32'h2);
    rd_chk("err_addr_rw", 21'h1E1, 32'h041);
    rd_chk("acc_no_err", 21'h1E4, 32'(acc_exp));
    wr_ctl(21'h1E0, 32'h3);

    wr_ctl(21'h1E2, 32'h4);
    rd_chk("irq_en", 21'h1E2, 32'h4);
    @(negedge clk);
    slot_irq = 16'h0004;
    @(posedge clk); #1;
    chk("irq_lat1", 32'(irq0), 32'h0);
    rd_chk("pend_set", 21'h1E3, 32'h4);
    chk("irq_lat2", 32'(irq0), 32'h1);
    rd_chk("status_irq", 21'h1E0, 32'h4);
    @(negedge clk);
    slot_irq = 16'h0000;
    @(posedge clk); #1;
    @(negedge clk);
    slot_irq = 16'h0004;
    mmio_cs = 1'b1; mmio_rd = 1'b0; mmio_wr = 1'b1; mmio_addr = 21'h1E3; mmio_wr_data = 32'h4;
    tick();
    acc_exp++;
    rd_chk("pend_set_wins", 21'h1E3, 32'h4);
    chk("irq_still", 32'(irq0), 32'h1);
    wr_ctl(21'h1E3, 32'h4);
    chk("irq_hold", 32'(irq0), 32'h1);
    @(posedge clk); #1;
    chk("irq_clr", 32'(irq0), 32'h0);
    chk("irq_clr_pipe", 32'(irq1), 32'h0);
    rd_chk("pend_clr", 21'h1E3, 32'h0);

    wr_ctl(21'h1E4, 32'h0);
    acc_exp = 0;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b1, 1'b0, 21'h060, 32'h0);
      tick();
      acc_exp++;
    end
    rd_chk("acc_ten", 21'h1E4, 32'd10);
    wr_ctl(21'h1E4, 32'h1);
    acc_exp = 0;
    rd_chk("acc_clear_wins", 21'h1E4, 32'd0);

    @(negedge clk);
    slot_irq = 16'h0000;
    @(posedge clk);
    @(negedge clk);
    slot_irq = 16'h0004;
    @(posedge clk);
    @(posedge clk); #1;
    chk("irq_pre_rst", 32'(irq0), 32'h1);
    drive(1'b1, 1'b1, 1'b0, 21'h060, 32'h0);
    @(posedge clk); #1;
    chk("pipe_pre_rst", rd1, 32'h0000_1234);
    #2;
    reset = 1'b1;
    #1;
    chk("rst_mid_pipe", rd1, 32'h0);
    chk("rst_mid_irq", 32'(irq0 | irq1), 32'h0);
    chk("rst_mid_strobes", 32'(cs0 | mr0 | mw0), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    mmio_cs = 1'b1; mmio_rd = 1'b1; mmio_wr = 1'b0; mmio_addr = 21'h1E3;
    #1;
    chk("pend_after_rst", rd0, 32'h0);
    tick();
    chk("pend_after_rst_pipe", rd1, 32'h0);
    acc_exp = 1;
    rd_chk("pend_level", 21'h1E3, 32'h4);
    rd_chk("status_after_rst", 21'h1E0, 32'h0);
    rd_chk("irq_en_after_rst", 21'h1E2, 32'h0);
    rd_chk("err_addr_after_rst", 21'h1E1, 32'h0);
    rd_chk("acc_after_rst", 21'h1E4, 32'(acc_exp));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
